// File: rtl/riscv_pkg.sv
// Shared widths, constants and helpers for the decode-side operand stage.
package riscv_pkg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;
    localparam int CTRL_W  = 16;

    localparam logic [RADDR_W-1:0] REG_ZERO = 5'd0;

    // A producer only bypasses when it writes a real register matching the source.
    function automatic logic fwd_hit(
        input logic               wen,
        input logic [RADDR_W-1:0] prod_rd,
        input logic [RADDR_W-1:0] rs
    );
        return wen && (prod_rd != REG_ZERO) && (prod_rd == rs);
    endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// Priority bypass select for one source operand: x0, EX, MEM, WB, register file.
module operand_fwd_mux
    import riscv_pkg::*;
(
    input  logic [RADDR_W-1:0] rs,
    input  logic [XLEN-1:0]    rf_rdata,
    input  logic [RADDR_W-1:0] ex_rd,
    input  logic               ex_wen,
    input  logic               ex_is_load,
    input  logic [XLEN-1:0]    ex_result,
    input  logic [RADDR_W-1:0] mem_rd,
    input  logic               mem_wen,
    input  logic [XLEN-1:0]    mem_data,
    input  logic [RADDR_W-1:0] wb_rd,
    input  logic               wb_wen,
    input  logic [XLEN-1:0]    wb_wdata,
    output logic [XLEN-1:0]    val
);

    // Youngest producer wins; a load in EX has no data yet, so it is skipped here.
    always_comb begin
        // NOTE: default first so every path assigns val and no latch is inferred.
        val = rf_rdata;
        if (rs == REG_ZERO) begin
            val = '0;
        end else if (fwd_hit(ex_wen && !ex_is_load, ex_rd, rs)) begin
            val = ex_result;
        end else if (fwd_hit(mem_wen, mem_rd, rs)) begin
            val = mem_data;
        end else if (fwd_hit(wb_wen, wb_rd, rs)) begin
            val = wb_wdata;
        end
    end

endmodule

// File: rtl/id_operand_stage.sv
// Operand stage: register-file addressing, RAW bypass, load-use stall and the
// ID/EX pipeline register with valid/ready handshakes on both sides.
module id_operand_stage
    import riscv_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [RADDR_W-1:0] in_rs1,
    input  logic [RADDR_W-1:0] in_rs2,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic               in_rd_wen,
    input  logic               in_is_load,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [CTRL_W-1:0]  in_ctrl,
    output logic [RADDR_W-1:0] rf_raddr1,
    output logic [RADDR_W-1:0] rf_raddr2,
    input  logic [XLEN-1:0]    rf_rdata1,
    input  logic [XLEN-1:0]    rf_rdata2,
    input  logic [RADDR_W-1:0] ex_rd,
    input  logic               ex_wen,
    input  logic               ex_is_load,
    input  logic [XLEN-1:0]    ex_result,
    input  logic [RADDR_W-1:0] mem_rd,
    input  logic               mem_wen,
    input  logic [XLEN-1:0]    mem_data,
    input  logic [RADDR_W-1:0] wb_rd,
    input  logic               wb_wen,
    input  logic [XLEN-1:0]    wb_wdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_rs1_val,
    output logic [XLEN-1:0]    out_rs2_val,
    output logic [RADDR_W-1:0] out_rd,
    output logic               out_rd_wen,
    output logic               out_is_load,
    output logic [XLEN-1:0]    out_pc,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [31:0]        stall_cnt
);

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            hazard;
    logic            adv;
    logic            capture;

    assign rf_raddr1 = in_rs1;
    assign rf_raddr2 = in_rs2;

    // Load in EX feeding this instruction: its data only exists from MEM onward.
    assign hazard  = in_valid && ex_wen && ex_is_load && (ex_rd != REG_ZERO)
                     && ((ex_rd == in_rs1) || (ex_rd == in_rs2));
    assign adv     = !out_valid || out_ready;
    assign in_ready = flush || (adv && !hazard);
    assign capture = !flush && adv && in_valid && !hazard;

    operand_fwd_mux u_fwd_rs1 (
        .rs         (in_rs1),
        .rf_rdata   (rf_rdata1),
        .ex_rd      (ex_rd),
        .ex_wen     (ex_wen),
        .ex_is_load (ex_is_load),
        .ex_result  (ex_result),
        .mem_rd     (mem_rd),
        .mem_wen    (mem_wen),
        .mem_data   (mem_data),
        .wb_rd      (wb_rd),
        .wb_wen     (wb_wen),
        .wb_wdata   (wb_wdata),
        .val        (rs1_val)
    );

    operand_fwd_mux u_fwd_rs2 (
        .rs         (in_rs2),
        .rf_rdata   (rf_rdata2),
        .ex_rd      (ex_rd),
        .ex_wen     (ex_wen),
        .ex_is_load (ex_is_load),
        .ex_result  (ex_result),
        .mem_rd     (mem_rd),
        .mem_wen    (mem_wen),
        .mem_data   (mem_data),
        .wb_rd      (wb_rd),
        .wb_wen     (wb_wen),
        .wb_wdata   (wb_wdata),
        .val        (rs2_val)
    );

    // ID/EX register: flush kills, advance loads or bubbles, backpressure holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            out_valid   <= 1'b0;
            out_rs1_val <= '0;
            out_rs2_val <= '0;
            out_rd      <= '0;
            out_rd_wen  <= 1'b0;
            out_is_load <= 1'b0;
            out_pc      <= '0;
            out_ctrl    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (adv) begin
            out_valid <= in_valid && !hazard;
            if (capture) begin
                out_rs1_val <= rs1_val;
                out_rs2_val <= rs2_val;
                out_rd      <= in_rd;
                out_rd_wen  <= in_rd_wen;
                out_is_load <= in_is_load;
                out_pc      <= in_pc;
                out_ctrl    <= in_ctrl;
            end
        end
    end

    // Saturating count of cycles spent inserting a load-use bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (hazard && adv && !flush && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed and randomized bench for id_operand_stage with a scoreboard of
// expected ID/EX contents, pushed at acceptance and popped when consumed.
module tb_id_operand_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_rd_wen, in_is_load;
    logic [31:0] in_pc;
    logic [15:0] in_ctrl;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic [4:0]  ex_rd, mem_rd, wb_rd;
    logic        ex_wen, ex_is_load, mem_wen, wb_wen;
    logic [31:0] ex_result, mem_data, wb_wdata;
    logic        out_valid, out_ready;
    logic [31:0] out_rs1_val, out_rs2_val, out_pc;
    logic [4:0]  out_rd;
    logic        out_rd_wen, out_is_load;
    logic [15:0] out_ctrl;
    logic [31:0] stall_cnt;

    typedef struct {
        logic [31:0] v1;
        logic [31:0] v2;
        logic [4:0]  rd;
        logic        wen;
        logic        ld;
        logic [31:0] pc;
        logic [15:0] ctrl;
    } exp_t;

    exp_t        sb[$];
    logic        m_valid;
    logic [31:0] m_stall;
    int          total;
    int          passed;

    id_operand_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_rd_wen(in_rd_wen), .in_is_load(in_is_load),
        .in_pc(in_pc), .in_ctrl(in_ctrl),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_result(ex_result),
        .mem_rd(mem_rd), .mem_wen(mem_wen), .mem_data(mem_data),
        .wb_rd(wb_rd), .wb_wen(wb_wen), .wb_wdata(wb_wdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_rd(out_rd), .out_rd_wen(out_rd_wen), .out_is_load(out_is_load),
        .out_pc(out_pc), .out_ctrl(out_ctrl), .stall_cnt(stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference operand resolution from the current bypass inputs.
    function automatic logic [31:0] ref_op(input logic [4:0] rs, input logic [31:0] rf);
        if (rs == 5'd0)                                         return 32'd0;
        if (ex_wen && !ex_is_load && ex_rd == rs && ex_rd != 0) return ex_result;
        if (mem_wen && mem_rd == rs && mem_rd != 0)             return mem_data;
        if (wb_wen && wb_rd == rs && wb_rd != 0)                return wb_wdata;
        return rf;
    endfunction

    task automatic set_idle();
        flush = 0; in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
        in_rd_wen = 0; in_is_load = 0; in_pc = 0; in_ctrl = 0;
        rf_rdata1 = 0; rf_rdata2 = 0;
        ex_rd = 0; ex_wen = 0; ex_is_load = 0; ex_result = 0;
        mem_rd = 0; mem_wen = 0; mem_data = 0;
        wb_rd = 0; wb_wen = 0; wb_wdata = 0;
        out_ready = 1;
    endtask

    task automatic set_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] pc);
        in_valid = 1; in_rs1 = rs1; in_rs2 = rs2; in_rd = pc[6:2];
        in_rd_wen = pc[2]; in_is_load = pc[3]; in_pc = pc; in_ctrl = pc[15:0] ^ 16'h5A5A;
    endtask

    // One clock: check handshake pre-edge, update model, check ID/EX post-edge.
    task automatic cycle();
        logic hz, advm, acc;
        #1;
        hz   = in_valid && ex_wen && ex_is_load && (ex_rd != 0)
               && ((ex_rd == in_rs1) || (ex_rd == in_rs2));
        advm = !m_valid || out_ready;
        acc  = !flush && advm && in_valid && !hz;
        check("in_ready", in_ready, flush || (advm && !hz));
        check("rf_raddr", {rf_raddr1, rf_raddr2}, {in_rs1, in_rs2});
        if (m_valid && (flush || out_ready)) void'(sb.pop_front());
        if (acc) sb.push_back('{ref_op(in_rs1, rf_rdata1), ref_op(in_rs2, rf_rdata2),
                                in_rd, in_rd_wen, in_is_load, in_pc, in_ctrl});
        if (flush) m_valid = 0;
        else if (advm) m_valid = acc;
        if (hz && advm && !flush && m_stall != 32'hFFFF_FFFF) m_stall++;
        @(posedge clk);
        #1;
        check("out_valid", out_valid, m_valid);
        check("stall_cnt", stall_cnt, m_stall);
        if (m_valid) begin
            check("sb_depth", sb.size(), 1);
            if (sb.size() != 0) begin
                check("out_rs1_val", out_rs1_val, sb[0].v1);
                check("out_rs2_val", out_rs2_val, sb[0].v2);
                check("out_rd", {out_rd, out_rd_wen, out_is_load},
                      {sb[0].rd, sb[0].wen, sb[0].ld});
                check("out_pc_ctrl", {out_pc, out_ctrl}, {sb[0].pc, sb[0].ctrl});
            end
        end
    endtask

    initial begin
        total = 0; passed = 0; m_valid = 0; m_stall = 0;
        set_idle();
        rst = 0;
        #2;
        check("reset_valid", out_valid, 1'b0);
        check("reset_stall", stall_cnt, 32'd0);
        check("reset_data", {out_rs1_val, out_rs2_val, out_pc}, 96'd0);
        @(negedge clk);
        rst = 1;

        // EX beats MEM on rs1; rs2 from register file.
        set_instr(5'd5, 5'd9, 32'h100);
        ex_rd = 5; ex_wen = 1; ex_result = 32'hAA;
        mem_rd = 5; mem_wen = 1; mem_data = 32'hBB;
        rf_rdata2 = 32'h99;
        cycle();
        check("t2_ex_wins", out_rs1_val, 32'hAA);
        check("t2_rf_rs2", out_rs2_val, 32'h99);

        // Only WB matches rs2.
        set_idle();
        set_instr(5'd1, 5'd7, 32'h104);
        wb_rd = 7; wb_wen = 1; wb_wdata = 32'h1234; rf_rdata1 = 32'h11;
        cycle();
        check("t3_wb_bypass", out_rs2_val, 32'h1234);

        // MEM beats WB.
        set_idle();
        set_instr(5'd4, 5'd4, 32'h108);
        mem_rd = 4; mem_wen = 1; mem_data = 32'h44;
        wb_rd = 4; wb_wen = 1; wb_wdata = 32'h55;
        cycle();
        check("mem_over_wb", out_rs1_val, 32'h44);

        // Load-use on x3: one bubble, then picked up from MEM.
        set_idle();
        set_instr(5'd3, 5'd2, 32'h10C);
        ex_rd = 3; ex_wen = 1; ex_is_load = 1; rf_rdata1 = 32'hDEAD;
        #1;
        check("t4_in_ready_low", in_ready, 1'b0);
        cycle();
        check("t4_bubble", out_valid, 1'b0);
        check("t4_stall_one", stall_cnt, 32'd1);
        ex_rd = 0; ex_wen = 0; ex_is_load = 0;
        mem_rd = 3; mem_wen = 1; mem_data = 32'hCAFE;
        cycle();
        check("t4_mem_pickup", out_rs1_val, 32'hCAFE);

        // Load-use through rs2.
        set_idle();
        set_instr(5'd6, 5'd8, 32'h110);
        ex_rd = 8; ex_wen = 1; ex_is_load = 1;
        cycle();
        check("rs2_hazard_stall", stall_cnt, 32'd2);

        // x0 is never forwarded, even from a producer writing x0.
        set_idle();
        set_instr(5'd0, 5'd0, 32'h114);
        ex_rd = 0; ex_wen = 1; ex_is_load = 0; ex_result = 32'hFF;
        cycle();
        check("t5_x0", out_rs1_val, 32'd0);
        ex_is_load = 1;
        cycle();
        check("x0_load_no_stall", stall_cnt, 32'd2);

        // Backpressure hold for 3 cycles, then flush drops the input.
        set_idle();
        set_instr(5'd1, 5'd2, 32'h118);
        rf_rdata1 = 32'h1111; rf_rdata2 = 32'h2222;
        cycle();
        set_instr(5'd3, 5'd4, 32'h11C);
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t6_held_pc", out_pc, 32'h118);
        end
        flush = 1;
        #1;
        check("t6_flush_ready", in_ready, 1'b1);
        cycle();
        check("t6_flushed", out_valid, 1'b0);
        flush = 0; out_ready = 1;

        // Randomized traffic with narrow register range to provoke bypasses and hazards.
        for (int i = 0; i < 60; i++) begin
            set_instr(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom);
            in_valid   = ($urandom_range(0, 4) != 0);
            rf_rdata1  = $urandom; rf_rdata2 = $urandom;
            ex_rd      = 5'($urandom_range(0, 3)); ex_wen = 1'($urandom);
            ex_is_load = 1'($urandom); ex_result = $urandom;
            mem_rd     = 5'($urandom_range(0, 3)); mem_wen = 1'($urandom); mem_data = $urandom;
            wb_rd      = 5'($urandom_range(0, 3)); wb_wen = 1'($urandom); wb_wdata = $urandom;
            out_ready  = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 9) == 0);
            cycle();
        end

        // Mid-stream asynchronous reset with a live instruction and nonzero stall count.
        set_idle();
        set_instr(5'd3, 5'd0, 32'h200);
        ex_rd = 3; ex_wen = 1; ex_is_load = 1;
        cycle();
        set_idle();
        set_instr(5'd1, 5'd0, 32'h204);
        cycle();
        check("pre_reset_valid", out_valid, 1'b1);
        rst = 0;
        #1;
        check("t1_async_valid", out_valid, 1'b0);
        check("t1_async_stall", stall_cnt, 32'd0);
        sb.delete(); m_valid = 0; m_stall = 0;
        @(negedge clk);
        rst = 1;
        set_idle();
        cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
